imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 34 +++
 rtl/imem_responder_if.sv | 39 +++
 rtl/imem_responder_resp_fifo2.sv | 54 +++++
 rtl/imem_responder.sv | 94 +++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder:
// fault encoding, response FIFO entry layout and the fault classifier.
package imem_pkg;

  localparam int          DEPTH_WORDS_DEFAULT = 256;
  localparam logic [31:0] NOP_INSTR_DEFAULT   = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    fault_e      fault;
  } rsp_entry_t;

  // Misalignment wins over out-of-range when both apply.
  function automatic fault_e classify_fault(input logic [31:0] addr,
                                            input int unsigned depth_words);
    fault_e f;
    if (addr[1:0] != 2'b00) begin
      f = FAULT_MISALIGN;
    end else if ({2'b00, addr[31:2]} >= 32'(depth_words)) begin
      f = FAULT_RANGE;
    end else begin
      f = FAULT_OK;
    end
    return f;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / response bus between a fetch unit (master) and the
// instruction-memory responder (slave).
interface imem_responder_if;

  // Both channels use valid/ready: a transfer happens on a rising clk edge
  // where valid && ready; the sender holds its payload while valid && !ready.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic [1:0]  rsp_fault;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_pc,
    input  rsp_fault
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_pc,
    output rsp_fault
  );

endinterface

// File: rtl/imem_responder_resp_fifo2.sv
// Two-entry response FIFO holding {pc, instr, fault}; flush empties it
// in one cycle, and push+pop while full keeps it full.
module resp_fifo2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  rsp_entry_t push_data,
  input  logic       pop,
  output rsp_entry_t head,
  output logic       empty,
  output logic [1:0] count
);

  rsp_entry_t entries [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       full;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = entries[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-stage address register (S1) feeding a
// two-entry response FIFO; memory is filled through a separate load port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  imem_responder_if.slave                bus,
  input  logic                           flush,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic        s1_valid;
  logic [31:0] s1_addr;
  fault_e      s1_fault;

  logic        accept;
  logic        pop;
  logic [1:0]  occupancy;
  logic [31:0] mem_rdata;

  rsp_entry_t  push_data;
  rsp_entry_t  head;
  logic        fifo_empty;
  logic [1:0]  fifo_count;

  // A pop this cycle frees a slot, so a full pipe can still accept.
  assign occupancy     = {1'b0, s1_valid} + fifo_count;
  assign bus.req_ready = !reset && !flush &&
                         ((occupancy < 2'd2) || (bus.rsp_valid && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_fault <= FAULT_OK;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr  <= bus.req_addr;
        s1_fault <= classify_fault(bus.req_addr, DEPTH_WORDS);
      end
    end
  end

  // The array is read combinationally during S1, so a load landing at the
  // end of that same cycle is seen only by later fetches (read-first).
  always_ff @(posedge clk) begin
    if (!reset && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign mem_rdata = mem[s1_addr[AW+1:2]];

  always_comb begin
    push_data       = '0;
    push_data.pc    = s1_addr;
    push_data.fault = s1_fault;
    push_data.instr = (s1_fault == FAULT_OK) ? mem_rdata : NOP_INSTR;
  end

  resp_fifo2 u_resp_fifo2 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (s1_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs read as zero for every cycle reset is high, including the first.
  assign bus.rsp_valid = !reset && !fifo_empty;
  assign bus.rsp_instr = reset ? 32'd0 : head.instr;
  assign bus.rsp_pc    = reset ? 32'd0 : head.pc;
  assign bus.rsp_fault = reset ? 2'b00 : head.fault;

endmodule
